alarm_panel: RTL

ALARM_PANEL -- requirements
Module: alarm_panel

---
 rtl/alarm_panel_if.sv | 22 ++
 rtl/alarm_panel.sv | 114 +++++++++++
 2 files changed

// File: rtl/alarm_panel_if.sv
// Keypad-side bus of the alarm panel: digit entry and command inputs, plus status outputs.
// The master (keypad or bench) drives the entry signals. The slave (panel) drives the status.
interface alarm_panel_if;
  logic [1:0] command;
  logic [3:0] digit;
  logic       digit_entered;
  logic       armed;
  logic       locked;
  logic       code_ok;
  logic       code_bad;
  logic [1:0] entry_count;

  modport master (
    output command, digit, digit_entered,
    input  armed, locked, code_ok, code_bad, entry_count
  );

  modport slave (
    input  command, digit, digit_entered,
    output armed, locked, code_ok, code_bad, entry_count
  );
endinterface

// File: rtl/alarm_panel.sv
// Three-digit BCD keypad alarm panel: arm/disarm/change-code with a stored code,
// a consecutive-failure counter and a timed lockout after too many bad entries.
module alarm_panel #(
  parameter logic [11:0] CODE_RESET  = 12'h123,
  parameter int          MAX_FAIL    = 3,
  parameter int          LOCK_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  alarm_panel_if.slave bus
);

  typedef enum logic [1:0] {
    CMD_NOP    = 2'b00,
    CMD_ARM    = 2'b01,
    CMD_DISARM = 2'b10,
    CMD_CHANGE = 2'b11
  } cmd_e;

  logic [11:0] stored_code;
  logic [7:0]  entry_buf;
  logic [1:0]  entry_count;
  logic [3:0]  fail_count;
  logic [15:0] lock_count;
  logic        armed_q;
  logic        locked_q;
  logic        ok_q;
  logic        bad_q;

  cmd_e        cmd;
  logic [11:0] entered;
  logic        digit_valid;
  logic        code_match;
  logic        fail_limit;

  // The third digit is evaluated live from the bus, so only the first two are buffered.
  assign cmd         = cmd_e'(bus.command);
  assign entered     = {entry_buf, bus.digit};
  assign digit_valid = (bus.digit <= 4'd9);
  assign code_match  = (entered == stored_code);
  assign fail_limit  = (fail_count == 4'(MAX_FAIL - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stored_code <= CODE_RESET;
      entry_buf   <= '0;
      entry_count <= '0;
      fail_count  <= '0;
      lock_count  <= '0;
      armed_q     <= 1'b1;
      locked_q    <= 1'b0;
      ok_q        <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      ok_q  <= 1'b0;
      bad_q <= 1'b0;
      if (locked_q) begin
        // Counting down from LOCK_CYCLES and releasing on the 1->0 step keeps locked high exactly LOCK_CYCLES cycles.
        if (lock_count == 16'd1) begin
          locked_q   <= 1'b0;
          lock_count <= '0;
        end else begin
          lock_count <= lock_count - 16'd1;
        end
      end else if (bus.digit_entered) begin
        if (!digit_valid) begin
          entry_count <= '0;
        end else if (entry_count != 2'd2) begin
          entry_buf   <= entered[7:0];
          entry_count <= entry_count + 2'd1;
        end else begin
          entry_buf   <= entered[7:0];
          entry_count <= '0;
          case (cmd)
            CMD_ARM, CMD_DISARM: begin
              if (code_match) begin
                armed_q    <= (cmd == CMD_ARM);
                ok_q       <= 1'b1;
                fail_count <= '0;
              end else begin
                bad_q <= 1'b1;
                if (fail_limit) begin
                  locked_q   <= 1'b1;
                  lock_count <= 16'(LOCK_CYCLES);
                  fail_count <= '0;
                end else begin
                  fail_count <= fail_count + 4'd1;
                end
              end
            end
            CMD_CHANGE: begin
              // Re-keying is only allowed while disarmed. A refusal is not treated as a guessing attempt.
              if (!armed_q) begin
                stored_code <= entered;
                ok_q        <= 1'b1;
              end else begin
                bad_q <= 1'b1;
              end
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.armed       = armed_q;
  assign bus.locked      = locked_q;
  assign bus.code_ok     = ok_q;
  assign bus.code_bad    = bad_q;
  assign bus.entry_count = entry_count;

endmodule
